// File: rtl/tetris_seq.sv
`default_nettype none
// ============================================================================
// Module      : tetris_seq
// Description : Game phase sequencer for the Tetris datapath. Drives the
//               phase code, arbitrates button and gravity requests onto the
//               single move port, and counts landed pieces.
// Revision    : 1.0 - initial release
// ============================================================================
module tetris_seq #(
  parameter int DROP_TICKS   = 16,
  parameter int LAND_CYCLES  = 2,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_rotate,
  input  logic        touched,
  input  logic        error,
  output logic [3:0]  state,
  output logic [1:0]  move,
  output logic        move_valid,
  output logic        game_over,
  output logic [15:0] pieces
);

  localparam logic [3:0] c_ST_GEN      = 4'd0;
  localparam logic [3:0] c_ST_MOVE     = 4'd1;
  localparam logic [3:0] c_ST_LAND     = 4'd2;
  localparam logic [3:0] c_ST_CLEAR    = 4'd3;
  localparam logic [3:0] c_ST_NEWBOARD = 4'd4;
  localparam logic [3:0] c_ST_GAMEOVER = 4'd5;

  localparam logic [1:0] c_MV_LEFT   = 2'd0;
  localparam logic [1:0] c_MV_RIGHT  = 2'd1;
  localparam logic [1:0] c_MV_ROTATE = 2'd2;
  localparam logic [1:0] c_MV_DOWN   = 2'd3;

  localparam int c_GRAV_W = $clog2(DROP_TICKS);
  localparam int c_HOLD_MAX = (LAND_CYCLES > CLEAR_CYCLES) ? LAND_CYCLES : CLEAR_CYCLES;
  localparam int c_HOLD_W = $clog2(c_HOLD_MAX + 1);

  localparam logic [c_GRAV_W-1:0] c_GRAV_LAST  = c_GRAV_W'(DROP_TICKS - 1);
  localparam logic [c_HOLD_W-1:0] c_LAND_LAST  = c_HOLD_W'(LAND_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_CLEAR_LAST = c_HOLD_W'(CLEAR_CYCLES - 1);

  logic [3:0]          r_state;
  logic [1:0]          r_move;
  logic                r_move_valid;
  logic                r_game_over;
  logic [15:0]         r_pieces;
  logic [c_GRAV_W-1:0] r_gravity;
  logic [c_HOLD_W-1:0] r_hold;
  logic                r_pend_left, r_pend_right, r_pend_rotate, r_pend_drop;
  logic                r_after_go;

  logic [3:0]          w_state_nxt;
  logic [1:0]          w_move_nxt;
  logic                w_move_valid_nxt;
  logic [15:0]         w_pieces_nxt;
  logic [c_GRAV_W-1:0] w_gravity_nxt;
  logic [c_HOLD_W-1:0] w_hold_nxt;
  logic                w_pend_left_nxt, w_pend_right_nxt, w_pend_rotate_nxt, w_pend_drop_nxt;
  logic                w_in_move, w_drop_set, w_can_issue, w_flush;
  logic                w_iss_left, w_iss_right, w_iss_rotate, w_iss_drop;

  assign state      = r_state;
  assign move       = r_move;
  assign move_valid = r_move_valid;
  assign game_over  = r_game_over;
  assign pieces     = r_pieces;

  // State register plus all registered outputs and bookkeeping
  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      r_state       <= c_ST_NEWBOARD;
      r_move        <= c_MV_LEFT;
      r_move_valid  <= 1'b0;
      r_game_over   <= 1'b0;
      r_pieces      <= 16'd0;
      r_gravity     <= '0;
      r_hold        <= '0;
      r_pend_left   <= 1'b0;
      r_pend_right  <= 1'b0;
      r_pend_rotate <= 1'b0;
      r_pend_drop   <= 1'b0;
      r_after_go    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_move        <= w_move_nxt;
      r_move_valid  <= w_move_valid_nxt;
      r_game_over   <= (w_state_nxt == c_ST_GAMEOVER);
      r_pieces      <= w_pieces_nxt;
      r_gravity     <= w_gravity_nxt;
      r_hold        <= w_hold_nxt;
      r_pend_left   <= w_pend_left_nxt;
      r_pend_right  <= w_pend_right_nxt;
      r_pend_rotate <= w_pend_rotate_nxt;
      r_pend_drop   <= w_pend_drop_nxt;
      r_after_go    <= (r_state == c_ST_GAMEOVER) && (w_state_nxt == c_ST_NEWBOARD);
    end
  end

  // Phase transitions; unused codes fall back to NEWBOARD
  always_comb begin
    w_state_nxt = c_ST_NEWBOARD;
    case (r_state)
      c_ST_NEWBOARD: w_state_nxt = (r_after_go || start) ? c_ST_GEN : c_ST_NEWBOARD;
      c_ST_GEN:      w_state_nxt = error ? c_ST_GAMEOVER : c_ST_MOVE;
      c_ST_MOVE:     w_state_nxt = touched ? c_ST_LAND : c_ST_MOVE;
      c_ST_LAND:     w_state_nxt = (r_hold == c_LAND_LAST) ? c_ST_CLEAR : c_ST_LAND;
      c_ST_CLEAR:    w_state_nxt = (r_hold == c_CLEAR_LAST) ? c_ST_GEN : c_ST_CLEAR;
      c_ST_GAMEOVER: w_state_nxt = start ? c_ST_NEWBOARD : c_ST_GAMEOVER;
      default:       w_state_nxt = c_ST_NEWBOARD;
    endcase
  end

  // Move arbitration, pending bits, counters and piece tally
  always_comb begin
    w_in_move   = (r_state == c_ST_MOVE);
    w_drop_set  = w_in_move && (r_gravity == c_GRAV_LAST);
    // A move may issue only in MOVE, never alongside touched, and never back-to-back
    w_can_issue = w_in_move && !touched && !r_move_valid;

    w_iss_drop   = w_can_issue && (r_pend_drop | w_drop_set);
    w_iss_rotate = w_can_issue && !w_iss_drop && (r_pend_rotate | btn_rotate);
    w_iss_left   = w_can_issue && !w_iss_drop && !w_iss_rotate && (r_pend_left | btn_left);
    w_iss_right  = w_can_issue && !w_iss_drop && !w_iss_rotate && !w_iss_left
                   && (r_pend_right | btn_right);

    w_move_valid_nxt = w_iss_drop | w_iss_rotate | w_iss_left | w_iss_right;
    w_move_nxt = r_move;
    if (w_iss_drop)        w_move_nxt = c_MV_DOWN;
    else if (w_iss_rotate) w_move_nxt = c_MV_ROTATE;
    else if (w_iss_left)   w_move_nxt = c_MV_LEFT;
    else if (w_iss_right)  w_move_nxt = c_MV_RIGHT;

    // An issued bit survives only if it was already pending and a fresh request lands too
    w_flush = (w_in_move && touched) || (r_state == c_ST_GAMEOVER)
              || (w_state_nxt == c_ST_GAMEOVER);
    w_pend_left_nxt   = w_iss_left   ? (r_pend_left & btn_left)     : (r_pend_left | btn_left);
    w_pend_right_nxt  = w_iss_right  ? (r_pend_right & btn_right)   : (r_pend_right | btn_right);
    w_pend_rotate_nxt = w_iss_rotate ? (r_pend_rotate & btn_rotate) : (r_pend_rotate | btn_rotate);
    w_pend_drop_nxt   = w_iss_drop   ? (r_pend_drop & w_drop_set)   : (r_pend_drop | w_drop_set);
    if (w_flush) begin
      w_pend_left_nxt   = 1'b0;
      w_pend_right_nxt  = 1'b0;
      w_pend_rotate_nxt = 1'b0;
      w_pend_drop_nxt   = 1'b0;
    end

    w_gravity_nxt = '0;
    if (w_in_move && !w_drop_set) w_gravity_nxt = r_gravity + 1'b1;

    w_hold_nxt = '0;
    if (((r_state == c_ST_LAND) || (r_state == c_ST_CLEAR)) && (w_state_nxt == r_state))
      w_hold_nxt = r_hold + 1'b1;

    w_pieces_nxt = r_pieces;
    if ((r_state == c_ST_GAMEOVER) && (w_state_nxt == c_ST_NEWBOARD))
      w_pieces_nxt = 16'd0;
    else if ((r_state == c_ST_CLEAR) && (w_state_nxt == c_ST_GEN) && (r_pieces != 16'hFFFF))
      w_pieces_nxt = r_pieces + 16'd1;
  end

endmodule
`default_nettype wire
